// File: rtl/rs_issue_sched_pkg.sv
// Shared defines (MACHINE_WIDTH, ISSUE_WIDTH, RS_SCHED_CNT_WIDTH) and types for the RS issue scheduler.
`ifndef MACHINE_WIDTH
`define MACHINE_WIDTH 2
`endif
`ifndef ISSUE_WIDTH
`define ISSUE_WIDTH 2
`endif
`ifndef RS_SCHED_CNT_WIDTH
`define RS_SCHED_CNT_WIDTH 32
`endif

package rs_issue_sched_pkg;
  localparam int CNT_W = `RS_SCHED_CNT_WIDTH;

  typedef struct packed {
    logic [CNT_W-1:0] issue;
    logic [CNT_W-1:0] stall;
  } perf_cnt_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [31:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int k = 0; k < 32; k++) cnt = cnt + CNT_W'(v[k]);
    return cnt;
  endfunction
endpackage

// File: rtl/rs_issue_sched_age_pick.sv
// One-hot oldest pick: an eligible entry wins when it is older than every other eligible entry.
module age_pick #(
  parameter int RS_DEPTH = 16
) (
  input  logic [RS_DEPTH-1:0]               elig_i,
  input  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] older_i,
  output logic [RS_DEPTH-1:0]               pick_o
);
  always_comb begin
    pick_o = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      pick_o[i] = elig_i[i];
      for (int j = 0; j < RS_DEPTH; j++) begin
        if (j != i && elig_i[j] && !older_i[i][j]) pick_o[i] = 1'b0;
      end
    end
  end
endmodule

// File: rtl/rs_issue_sched.sv
// Oldest-first issue scheduler for one RS array using an age matrix.
// RS_SCHED_PERF_EN adds perf_issue_cnt / perf_stall_cnt outputs.
module rs_issue_sched
  import rs_issue_sched_pkg::*;
#(
  parameter int RS_DEPTH      = 16,
  parameter int ISSUE_WIDTH   = `ISSUE_WIDTH,
  parameter int MACHINE_WIDTH = `MACHINE_WIDTH
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    pipe_flush,
  input  logic [RS_DEPTH-1:0][MACHINE_WIDTH-1:0]  alloc_sel,
  input  logic [RS_DEPTH-1:0][ISSUE_WIDTH-1:0]    rs_wake_up,
  input  logic [ISSUE_WIDTH-1:0]                  fu_ready,
  output logic [ISSUE_WIDTH-1:0][RS_DEPTH-1:0]    issue_sel,
  output logic [RS_DEPTH-1:0]                     rs_use_en,
  output logic [ISSUE_WIDTH-1:0]                  issue_valid,
`ifdef RS_SCHED_PERF_EN
  output logic [CNT_W-1:0]                        perf_issue_cnt,
  output logic [CNT_W-1:0]                        perf_stall_cnt,
`endif
  output logic [RS_DEPTH-1:0]                     sched_valid
);
  logic [RS_DEPTH-1:0]               valid_q, valid_d;
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] older_q, older_d;
  logic [RS_DEPTH-1:0]               alloc;
  logic [ISSUE_WIDTH-1:0][RS_DEPTH-1:0] elig;

  always_comb begin
    alloc = '0;
    elig  = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      alloc[i] = |alloc_sel[i];
      for (int p = 0; p < ISSUE_WIDTH; p++)
        elig[p][i] = valid_q[i] & rs_wake_up[i][p] & fu_ready[p];
    end
  end

  // Each port sees only entries not already granted to a lower port.
  for (genvar p = 0; p < ISSUE_WIDTH; p++) begin : gen_port
    logic [RS_DEPTH-1:0] taken_in, taken_out, pick;
    if (p == 0) begin : g_first
      assign taken_in = '0;
    end else begin : g_next
      assign taken_in = gen_port[p-1].taken_out;
    end
    age_pick #(.RS_DEPTH(RS_DEPTH)) u_pick (
      .elig_i (elig[p] & ~taken_in),
      .older_i(older_q),
      .pick_o (pick)
    );
    assign taken_out      = taken_in | pick;
    assign issue_sel[p]   = pick;
    assign issue_valid[p] = |pick;
  end

  assign rs_use_en   = gen_port[ISSUE_WIDTH-1].taken_out;
  assign sched_valid = valid_q;

  always_comb begin
    valid_d = (valid_q & ~rs_use_en) | alloc;
    if (pipe_flush) valid_d = '0;
    older_d = older_q;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (alloc[i]) begin
        for (int j = 0; j < RS_DEPTH; j++) begin
          if (j != i) begin
            if (valid_q[j]) begin
              older_d[j][i] = 1'b1;
              older_d[i][j] = 1'b0;
            end else if (alloc[j]) begin
              // one-hot slot selects compare numerically: lower slot is older
              older_d[i][j] = (alloc_sel[i] < alloc_sel[j]);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      older_q <= '0;
    end else begin
      valid_q <= valid_d;
      older_q <= older_d;
    end
  end

`ifdef RS_SCHED_PERF_EN
  perf_cnt_t perf_q, perf_d;
  logic      stall;

  always_comb begin
    stall = 1'b0;
    for (int i = 0; i < RS_DEPTH; i++)
      for (int p = 0; p < ISSUE_WIDTH; p++)
        stall = stall | (valid_q[i] & rs_wake_up[i][p] & ~fu_ready[p]);
    perf_d.issue = perf_q.issue + popcount(32'(issue_valid));
    perf_d.stall = perf_q.stall + CNT_W'(stall);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_issue_cnt = perf_q.issue;
  assign perf_stall_cnt = perf_q.stall;
`endif
endmodule

// File: tb/tb_rs_issue_sched.sv
// Directed table-driven bench for rs_issue_sched (RS_DEPTH=16, 2 issue ports, 2 dispatch slots).
module tb_rs_issue_sched;
  localparam int D = 16;
  localparam int IW = 2;
  localparam int MW = 2;

  logic                      clk, rst_n, pipe_flush;
  logic [D-1:0][MW-1:0]      alloc_sel;
  logic [D-1:0][IW-1:0]      rs_wake_up;
  logic [IW-1:0]             fu_ready;
  logic [IW-1:0][D-1:0]      issue_sel;
  logic [D-1:0]              rs_use_en;
  logic [IW-1:0]             issue_valid;
  logic [D-1:0]              sched_valid;
`ifdef RS_SCHED_PERF_EN
  logic [31:0]               perf_issue_cnt, perf_stall_cnt;
`endif

  rs_issue_sched #(.RS_DEPTH(D), .ISSUE_WIDTH(IW), .MACHINE_WIDTH(MW)) dut (
    .clk(clk), .rst_n(rst_n), .pipe_flush(pipe_flush),
    .alloc_sel(alloc_sel), .rs_wake_up(rs_wake_up), .fu_ready(fu_ready),
    .issue_sel(issue_sel), .rs_use_en(rs_use_en), .issue_valid(issue_valid),
`ifdef RS_SCHED_PERF_EN
    .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
    .sched_valid(sched_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < D; i++)
        assert (!(|alloc_sel[i] && sched_valid[i]))
          else $error("alloc of already-valid entry %0d", i);
    end
  end

  typedef struct {
    int          a0, a1;
    logic [15:0] wk0, wk1;
    logic [1:0]  fu;
    logic        fl;
    logic [15:0] es0, es1, esv;
  } vec_t;

  vec_t tbl[30];
  int   nchk = 0;
  int   nerr = 0;

  function automatic vec_t mk(int a0, int a1, logic [15:0] wk0, logic [15:0] wk1,
                              logic [1:0] fu, logic fl,
                              logic [15:0] es0, logic [15:0] es1, logic [15:0] esv);
    vec_t v;
    v.a0 = a0; v.a1 = a1; v.wk0 = wk0; v.wk1 = wk1; v.fu = fu; v.fl = fl;
    v.es0 = es0; v.es1 = es1; v.esv = esv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input int idx);
    vec_t v;
    string s;
    logic [15:0] euse;
    v = tbl[idx];
    alloc_sel = '0;
    if (v.a0 >= 0) alloc_sel[v.a0][0] = 1'b1;
    if (v.a1 >= 0) alloc_sel[v.a1][1] = 1'b1;
    for (int i = 0; i < D; i++) rs_wake_up[i] = {v.wk1[i], v.wk0[i]};
    fu_ready   = v.fu;
    pipe_flush = v.fl;
    @(negedge clk);
    euse = v.es0 | v.es1;
    s = $sformatf("row%0d", idx);
    chk({s, " sched_valid"}, 32'(sched_valid), 32'(v.esv));
    chk({s, " issue_sel0"},  32'(issue_sel[0]), 32'(v.es0));
    chk({s, " issue_sel1"},  32'(issue_sel[1]), 32'(v.es1));
    chk({s, " rs_use_en"},   32'(rs_use_en), 32'(euse));
    chk({s, " issue_valid"}, 32'(issue_valid), 32'({|v.es1, |v.es0}));
    @(posedge clk);
    #1;
  endtask

  initial begin
    // back-pressure: entry 8 on port 1
    tbl[0]  = mk( 8, -1, 16'h0000, 16'h0000, 2'b11, 0, 16'h0000, 16'h0000, 16'h0000);
    tbl[1]  = mk(-1, -1, 16'h0000, 16'h0100, 2'b01, 0, 16'h0000, 16'h0000, 16'h0100);
    tbl[2]  = mk(-1, -1, 16'h0000, 16'h0100, 2'b01, 0, 16'h0000, 16'h0000, 16'h0100);
    tbl[3]  = mk(-1, -1, 16'h0000, 16'h0100, 2'b01, 0, 16'h0000, 16'h0000, 16'h0100);
    tbl[4]  = mk(-1, -1, 16'h0000, 16'h0100, 2'b11, 0, 16'h0000, 16'h0100, 16'h0100);
    tbl[5]  = mk(-1, -1, 16'h0000, 16'h0000, 2'b11, 0, 16'h0000, 16'h0000, 16'h0000);
    // multi-port: 3 older than 7; wake in alloc cycle ignored
    tbl[6]  = mk( 3,  7, 16'h0088, 16'h0088, 2'b11, 0, 16'h0000, 16'h0000, 16'h0000);
    tbl[7]  = mk(-1, -1, 16'h0008, 16'h0088, 2'b11, 0, 16'h0008, 16'h0080, 16'h0088);
    tbl[8]  = mk(-1, -1, 16'h0000, 16'h0000, 2'b11, 0, 16'h0000, 16'h0000, 16'h0000);
    // age order 5, 2, 9 on port 0
    tbl[9]  = mk( 5,  2, 16'h0000, 16'h0000, 2'b11, 0, 16'h0000, 16'h0000, 16'h0000);
    tbl[10] = mk( 9, -1, 16'h0000, 16'h0000, 2'b11, 0, 16'h0000, 16'h0000, 16'h0024);
    tbl[11] = mk(-1, -1, 16'h0224, 16'h0000, 2'b01, 0, 16'h0020, 16'h0000, 16'h0224);
    tbl[12] = mk(-1, -1, 16'h0224, 16'h0000, 2'b01, 0, 16'h0004, 16'h0000, 16'h0204);
    tbl[13] = mk(-1, -1, 16'h0224, 16'h0000, 2'b01, 0, 16'h0200, 16'h0000, 16'h0200);
    tbl[14] = mk(-1, -1, 16'h0000, 16'h0000, 2'b01, 0, 16'h0000, 16'h0000, 16'h0000);
    // port 1 alone: 11 (slot 0) older than 10
    tbl[15] = mk(11, 10, 16'h0000, 16'h0000, 2'b11, 0, 16'h0000, 16'h0000, 16'h0000);
    tbl[16] = mk(-1, -1, 16'h0000, 16'h0C00, 2'b10, 0, 16'h0000, 16'h0800, 16'h0C00);
    tbl[17] = mk(-1, -1, 16'h0000, 16'h0C00, 2'b10, 0, 16'h0000, 16'h0400, 16'h0400);
    tbl[18] = mk(-1, -1, 16'h0000, 16'h0000, 2'b11, 0, 16'h0000, 16'h0000, 16'h0000);
    // flush beats same-cycle alloc of 4
    tbl[19] = mk( 1,  6, 16'h0000, 16'h0000, 2'b11, 0, 16'h0000, 16'h0000, 16'h0000);
    tbl[20] = mk( 4, -1, 16'h0000, 16'h0000, 2'b11, 1, 16'h0000, 16'h0000, 16'h0042);
    tbl[21] = mk(-1, -1, 16'hFFFF, 16'hFFFF, 2'b11, 0, 16'h0000, 16'h0000, 16'h0000);
    // grant still visible in flush cycle
    tbl[22] = mk( 1, -1, 16'h0000, 16'h0000, 2'b11, 0, 16'h0000, 16'h0000, 16'h0000);
    tbl[23] = mk(-1, -1, 16'h0002, 16'h0000, 2'b11, 1, 16'h0002, 16'h0000, 16'h0002);
    tbl[24] = mk(-1, -1, 16'hFFFF, 16'hFFFF, 2'b11, 0, 16'h0000, 16'h0000, 16'h0000);
    // 12 then 13/14: both ports split the two oldest
    tbl[25] = mk(12, -1, 16'h0000, 16'h0000, 2'b11, 0, 16'h0000, 16'h0000, 16'h0000);
    tbl[26] = mk(13, 14, 16'h0000, 16'h0000, 2'b11, 0, 16'h0000, 16'h0000, 16'h1000);
    tbl[27] = mk(-1, -1, 16'h7000, 16'h7000, 2'b11, 0, 16'h1000, 16'h2000, 16'h7000);
    tbl[28] = mk(-1, -1, 16'h7000, 16'h7000, 2'b11, 0, 16'h4000, 16'h0000, 16'h4000);
    tbl[29] = mk(-1, -1, 16'h0000, 16'h0000, 2'b11, 0, 16'h0000, 16'h0000, 16'h0000);

    rst_n = 1'b0; pipe_flush = 1'b0; alloc_sel = '0; rs_wake_up = '0; fu_ready = '0;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < D; i++) rs_wake_up[i] = IW'($urandom_range(3));
      fu_ready = 2'b11;
      @(negedge clk);
      chk("reset sched_valid", 32'(sched_valid), 32'h0);
      chk("reset issue_sel",   32'(issue_sel), 32'h0);
      chk("reset rs_use_en",   32'(rs_use_en), 32'h0);
      chk("reset issue_valid", 32'(issue_valid), 32'h0);
    end
    rs_wake_up = '0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int r = 0; r < 9; r++) apply(r);
`ifdef RS_SCHED_PERF_EN
    chk("perf_stall_cnt", perf_stall_cnt, 32'd3);
    chk("perf_issue_cnt", perf_issue_cnt, 32'd3);
`endif
    for (int r = 9; r < 30; r++) apply(r);

    // asynchronous reset mid-operation
    alloc_sel = '0;
    alloc_sel[0][0]  = 1'b1;
    alloc_sel[15][1] = 1'b1;
    rs_wake_up = '0;
    @(posedge clk);
    #1;
    alloc_sel = '0;
    chk("midrst pre sched_valid", 32'(sched_valid), 32'h8001);
    for (int i = 0; i < D; i++) rs_wake_up[i] = 2'b11;
    fu_ready = 2'b11;
    #1;
    chk("midrst pre issue_sel0", 32'(issue_sel[0]), 32'h0001);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst sched_valid", 32'(sched_valid), 32'h0);
    chk("midrst rs_use_en",   32'(rs_use_en), 32'h0);
    chk("midrst issue_valid", 32'(issue_valid), 32'h0);
`ifdef RS_SCHED_PERF_EN
    chk("midrst perf_issue_cnt", perf_issue_cnt, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
